// File: rtl/cs_i2s_tx_serializer.sv
// Philips I2S transmitter for the Cirrus DAC: 64 SCLK per frame, MCLK/LRCK = 256,
// one buffered stereo pair, silence plus underflow count when the buffer is empty.
module cs_i2s_tx_serializer #(
    parameter int unsigned AUDIO_WIDTH_P = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [AUDIO_WIDTH_P-1:0] x_left,
    input  logic [AUDIO_WIDTH_P-1:0] x_right,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic                     cs_tx_sclk,
    output logic                     cs_tx_lrck,
    output logic                     cs_tx_sdout,
    output logic                     frame_start,
    output logic [15:0]              underflow_cnt,
    input  logic                     underflow_clr
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SLOT_W = 5;
    localparam int unsigned UCNT_W = 16;

    logic [CNT_W-1:0]         cnt;
    logic [AUDIO_WIDTH_P-1:0] hold_left;
    logic [AUDIO_WIDTH_P-1:0] hold_right;
    logic [AUDIO_WIDTH_P-1:0] shift_left;
    logic [AUDIO_WIDTH_P-1:0] shift_right;

    logic                     load;
    logic                     accept;
    logic [SLOT_W-1:0]        slot;
    logic [SLOT_W-1:0]        bit_idx;
    logic [AUDIO_WIDTH_P-1:0] word;
    logic                     sel_bit;
    logic                     in_data;
    logic                     sdout_n;

    // Frame timing decode and serial bit select for the current count.
    always_comb begin
        load    = enable && (cnt == '0);
        accept  = x_valid && x_ready;
        slot    = cnt[6:2];
        bit_idx = SLOT_W'(AUDIO_WIDTH_P) - slot;
        word    = cnt[7] ? shift_right : shift_left;
        sel_bit = 1'b0;
        for (int unsigned i = 0; i < AUDIO_WIDTH_P; i++) begin
            if (bit_idx == SLOT_W'(i)) begin
                sel_bit = word[i];
            end
        end
        // Slot 0 is the I2S one-bit delay; slots past the sample width pad with zero.
        in_data = (slot != '0) && (slot <= SLOT_W'(AUDIO_WIDTH_P));
        sdout_n = in_data && sel_bit;
    end

    // Frame counter; held at zero while disabled so a restart begins a full left half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One-pair holding register; the frame load frees it, a handshake fills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_left  <= '0;
            hold_right <= '0;
            x_ready    <= 1'b1;
        end else begin
            if (accept) begin
                hold_left  <= x_left;
                hold_right <= x_right;
            end
            if (load && !x_ready) begin
                x_ready <= 1'b1;
            end else if (accept) begin
                x_ready <= 1'b0;
            end
        end
    end

    // Shift words: loaded at frame start, discarded when the serializer is stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_left  <= '0;
            shift_right <= '0;
        end else if (!enable) begin
            shift_left  <= '0;
            shift_right <= '0;
        end else if (load) begin
            shift_left  <= x_ready ? '0 : hold_left;
            shift_right <= x_ready ? '0 : hold_right;
        end
    end

    // Saturating underflow counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (underflow_clr) begin
            underflow_cnt <= '0;
        end else if (load && x_ready && (underflow_cnt != {UCNT_W{1'b1}})) begin
            underflow_cnt <= underflow_cnt + UCNT_W'(1);
        end
    end

    // Output stage: uniform one-clk lag, forced low while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_tx_sclk  <= 1'b0;
            cs_tx_lrck  <= 1'b0;
            cs_tx_sdout <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cs_tx_sclk  <= enable && cnt[1];
            cs_tx_lrck  <= enable && cnt[7];
            cs_tx_sdout <= enable && sdout_n;
            frame_start <= load;
        end
    end

endmodule

// File: tb/tb_cs_i2s_tx_serializer.sv
// Directed bench for cs_i2s_tx_serializer: frame timing, data framing, buffering,
// underflow counting/saturation, enable abort and asynchronous reset.
module tb_cs_i2s_tx_serializer;

    localparam int unsigned W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] x_left;
    logic [W-1:0] x_right;
    logic         x_valid;
    logic         x_ready;
    logic         cs_tx_sclk;
    logic         cs_tx_lrck;
    logic         cs_tx_sdout;
    logic         frame_start;
    logic [15:0]  underflow_cnt;
    logic         underflow_clr;

    cs_i2s_tx_serializer #(.AUDIO_WIDTH_P(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .x_left        (x_left),
        .x_right       (x_right),
        .x_valid       (x_valid),
        .x_ready       (x_ready),
        .cs_tx_sclk    (cs_tx_sclk),
        .cs_tx_lrck    (cs_tx_lrck),
        .cs_tx_sdout   (cs_tx_sdout),
        .frame_start   (frame_start),
        .underflow_cnt (underflow_cnt),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nerr = 0;
    int          wave_bad = 0;
    int          fs_bad = 0;
    int          ready_bad = 0;
    int          stream_k = 0;
    logic        stream_mode = 1'b0;
    logic [7:0]  mcnt = 8'd0;
    logic [31:0] lbits = '0;
    logic [31:0] rbits = '0;
    logic        prev_sclk = 1'b0;

    function automatic logic [W-1:0] sl(input int k);
        return 24'h123400 + 24'(k);
    endfunction

    function automatic logic [W-1:0] sr(input int k);
        return 24'hABC000 + 24'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: expected counter, SCLK/LRCK/frame_start waveform, bit capture, stream feed.
    task automatic tick();
        logic       en_e;
        logic [7:0] c_b;
        logic       acc;
        logic       rdy_b;
        en_e  = enable;
        c_b   = mcnt;
        acc   = x_valid && x_ready;
        rdy_b = x_ready;
        @(posedge clk);
        #1;
        mcnt = en_e ? c_b + 8'd1 : 8'd0;
        if (cs_tx_sclk !== (en_e & c_b[1])) wave_bad++;
        if (cs_tx_lrck !== (en_e & c_b[7])) wave_bad++;
        if (!en_e && cs_tx_sdout !== 1'b0) wave_bad++;
        if (frame_start !== (en_e && (c_b == 8'd0))) fs_bad++;
        if (!rdy_b && x_ready && !(en_e && (c_b == 8'd0))) ready_bad++;
        if (cs_tx_sclk && !prev_sclk) begin
            if (cs_tx_lrck) rbits = {rbits[30:0], cs_tx_sdout};
            else            lbits = {lbits[30:0], cs_tx_sdout};
        end
        prev_sclk = cs_tx_sclk;
        if (acc && stream_mode) begin
            stream_k++;
            x_left  = sl(stream_k);
            x_right = sr(stream_k);
        end
    endtask

    task automatic advance_to(input logic [7:0] c);
        int n;
        n = int'(8'(c - mcnt));
        repeat (n) tick();
    endtask

    // One full frame from cnt == 0; mode 1 starts streaming, mode 2 drops x_valid after the load.
    task automatic run_frame(input string tag, input logic [W-1:0] el, input logic [W-1:0] er,
                             input int mode);
        lbits = '0;
        rbits = '0;
        tick();
        if (mode == 1) begin
            stream_mode = 1'b1;
            stream_k    = 0;
            x_left      = sl(0);
            x_right     = sr(0);
            x_valid     = 1'b1;
        end else if (mode == 2) begin
            x_valid = 1'b0;
        end
        repeat (255) tick();
        check({tag, "_left"},  lbits, {1'b0, el, 7'b0});
        check({tag, "_right"}, rbits, {1'b0, er, 7'b0});
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        x_valid       = 1'b0;
        x_left        = '0;
        x_right       = '0;
        underflow_clr = 1'b0;
        #23;
        check("rst_ready", 32'(x_ready), 32'd1);
        check("rst_sclk",  32'(cs_tx_sclk), 32'd0);
        check("rst_lrck",  32'(cs_tx_lrck), 32'd0);
        check("rst_sdout", 32'(cs_tx_sdout), 32'd0);
        check("rst_fs",    32'(frame_start), 32'd0);
        check("rst_ucnt",  32'(underflow_cnt), 32'd0);

        // Idle: three silent frames, one underflow each.
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mcnt  = 8'd0;
        run_frame("idle0", 24'h0, 24'h0, 0);
        run_frame("idle1", 24'h0, 24'h0, 0);
        run_frame("idle2", 24'h0, 24'h0, 0);
        check("idle_ucnt", 32'(underflow_cnt), 32'd3);

        // Asynchronous reset clears the counter immediately.
        rst_n  = 1'b0;
        enable = 1'b0;
        #2;
        check("arst_ucnt", 32'(underflow_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mcnt  = 8'd0;

        // Pair loaded before the first frame.
        x_left  = 24'hA5A5A5;
        x_right = 24'h5A5A5A;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("cap_ready", 32'(x_ready), 32'd0);
        enable = 1'b1;
        run_frame("a5", 24'hA5A5A5, 24'h5A5A5A, 1);
        check("a5_ucnt", 32'(underflow_cnt), 32'd0);

        // Back-to-back streaming.
        for (int f = 0; f < 8; f++) begin
            run_frame("stream", sl(f), sr(f), 0);
        end
        stream_mode = 1'b0;
        x_valid     = 1'b0;
        run_frame("drain", sl(8), sr(8), 0);
        check("stream_hs", 32'(stream_k), 32'd9);
        check("stream_ucnt", 32'(underflow_cnt), 32'd0);
        check("stream_ready_rise", 32'(ready_bad), 32'd0);

        // Handshake coinciding with the load of an empty holder.
        x_left  = 24'h0F1E2D;
        x_right = 24'h3C4B5A;
        x_valid = 1'b1;
        run_frame("coll_silent", 24'h0, 24'h0, 2);
        check("coll_ucnt", 32'(underflow_cnt), 32'd1);
        check("coll_ready", 32'(x_ready), 32'd0);
        run_frame("coll_next", 24'h0F1E2D, 24'h3C4B5A, 0);
        check("coll_ucnt2", 32'(underflow_cnt), 32'd1);

        // Saturation and clear priority.
        advance_to(8'd10);
        force dut.underflow_cnt = 16'hFFFE;
        #1;
        release dut.underflow_cnt;
        check("sat_preset", 32'(underflow_cnt), 32'h0000FFFE);
        advance_to(8'd0);
        tick();
        check("sat_reach", 32'(underflow_cnt), 32'h0000FFFF);
        advance_to(8'd0);
        tick();
        check("sat_hold", 32'(underflow_cnt), 32'h0000FFFF);
        advance_to(8'd0);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check("clr_vs_inc", 32'(underflow_cnt), 32'd0);
        advance_to(8'd0);
        tick();
        check("inc_after_clr", 32'(underflow_cnt), 32'd1);

        // Enable dropped mid-frame with a buffered pair.
        advance_to(8'd50);
        x_left  = 24'h876543;
        x_right = 24'h13579B;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("en_cap_ready", 32'(x_ready), 32'd0);
        advance_to(8'd100);
        enable = 1'b0;
        tick();
        check("en_off_outs", 32'({cs_tx_sclk, cs_tx_lrck, cs_tx_sdout}), 32'd0);
        repeat (49) tick();
        check("en_off_hold", 32'(x_ready), 32'd0);
        enable = 1'b1;
        run_frame("reenable", 24'h876543, 24'h13579B, 0);
        check("reenable_ucnt", 32'(underflow_cnt), 32'd1);

        // Reset mid-frame drops the buffered pair.
        advance_to(8'd20);
        x_left  = 24'h111111;
        x_right = 24'h222222;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("pre_rst_ready", 32'(x_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(x_ready), 32'd1);
        check("mid_rst_ucnt", 32'(underflow_cnt), 32'd0);
        check("mid_rst_outs", 32'({cs_tx_sclk, cs_tx_lrck, cs_tx_sdout, frame_start}), 32'd0);

        check("waveform", 32'(wave_bad), 32'd0);
        check("frame_start", 32'(fs_bad), 32'd0);
        check("ready_rise", 32'(ready_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
